// File: rtl/memory_access_pkg.sv
// rtl/memory_access_pkg.sv - shared types and constants for the memory access stage
//
// Contents:
//   MEM_WIDTH_*        size codes carried in width[1:0]
//   WIDTH_UNSIGNED_BIT position of the zero-extend flag inside width
//   mem_state_t        transaction FSM states
//   BYTE_MASK_*        unshifted byte-lane masks per access size
package memory_access_pkg;

  localparam logic [1:0] MEM_WIDTH_BYTE  = 2'b00;
  localparam logic [1:0] MEM_WIDTH_HALF  = 2'b01;
  localparam logic [1:0] MEM_WIDTH_WORD  = 2'b10;
  localparam logic [1:0] MEM_WIDTH_DWORD = 2'b11;

  localparam int WIDTH_UNSIGNED_BIT = 2;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } mem_state_t;

  localparam logic [7:0] BYTE_MASK_B = 8'h01;
  localparam logic [7:0] BYTE_MASK_H = 8'h03;
  localparam logic [7:0] BYTE_MASK_W = 8'h0F;
  localparam logic [7:0] BYTE_MASK_D = 8'hFF;

endpackage

// File: rtl/memory_access_load_store_align.sv
// rtl/memory_access_load_store_align.sv - store lane alignment and load extraction/extension
//
// Ports:
//   addr       in   3  byte offset within the 64-bit word
//   width      in   3  {unsigned, size}
//   rs2        in  64  store data, right-justified
//   rdata      in  64  raw memory read data
//   byte_en    out  8  active byte lanes for this access
//   wdata      out 64  store data shifted into its lanes
//   load_data  out 64  extracted and sign/zero-extended load value
//   misaligned out  1  offset is not a multiple of the access size
module load_store_align
  import memory_access_pkg::*;
(
  input  logic [2:0]  addr,
  input  logic [2:0]  width,
  input  logic [63:0] rs2,
  input  logic [63:0] rdata,
  output logic [7:0]  byte_en,
  output logic [63:0] wdata,
  output logic [63:0] load_data,
  output logic        misaligned
);

  logic [7:0]  size_mask;
  logic [63:0] shifted;
  logic        zero_ext;

  assign zero_ext = width[WIDTH_UNSIGNED_BIT];
  assign shifted  = rdata >> {addr, 3'b000};
  assign wdata    = rs2 << {addr, 3'b000};
  assign byte_en  = size_mask << addr;

  always_comb begin
    size_mask  = BYTE_MASK_D;
    load_data  = shifted;
    misaligned = 1'b0;
    case (width[1:0])
      MEM_WIDTH_BYTE: begin
        size_mask = BYTE_MASK_B;
        load_data = zero_ext ? {56'd0, shifted[7:0]} : {{56{shifted[7]}}, shifted[7:0]};
      end
      MEM_WIDTH_HALF: begin
        size_mask  = BYTE_MASK_H;
        load_data  = zero_ext ? {48'd0, shifted[15:0]} : {{48{shifted[15]}}, shifted[15:0]};
        misaligned = addr[0];
      end
      MEM_WIDTH_WORD: begin
        size_mask  = BYTE_MASK_W;
        load_data  = zero_ext ? {32'd0, shifted[31:0]} : {{32{shifted[31]}}, shifted[31:0]};
        misaligned = (addr[1:0] != 2'b00);
      end
      default: begin
        // Doubleword: no extension, unsigned flag has no effect.
        size_mask  = BYTE_MASK_D;
        load_data  = shifted;
        misaligned = (addr != 3'b000);
      end
    endcase
  end

endmodule

// File: rtl/memory_access.sv
// rtl/memory_access.sv - memory pipeline stage: one req/ack data transaction per load/store
//
// Ports:
//   clk_in, rst_in                      clock (rising) and async active-high reset
//   alu_result_in / rs2_value_in        address or ALU result / store data
//   rd_in, width_signal_in              destination register / {unsigned, size}
//   rd_write/read/write/wb_src/valid    instruction control flags from execute
//   flush_signal_in, interrupt_signal_in squash an un-issued instruction
//   mem_ack_in, mem_rdata_in            memory completion and read data
//   mem_req/we/addr/wdata/byte_en_out   data memory request channel
//   alu_result/mem_data/rd/..._out      registered writeback-stage values
//   stall_signal_out                    combinational upstream freeze
//   misaligned/bus_error_signal_out     one-cycle exception pulses
module memory_access
  import memory_access_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [63:0] alu_result_in,
  input  logic [63:0] rs2_value_in,
  input  logic [4:0]  rd_in,
  input  logic [2:0]  width_signal_in,
  input  logic        rd_write_signal_in,
  input  logic        read_signal_in,
  input  logic        write_signal_in,
  input  logic        wb_src_signal_in,
  input  logic        valid_instr_signal_in,
  input  logic        flush_signal_in,
  input  logic        interrupt_signal_in,
  input  logic        mem_ack_in,
  input  logic [63:0] mem_rdata_in,
  output logic        mem_req_out,
  output logic        mem_we_out,
  output logic [63:0] mem_addr_out,
  output logic [63:0] mem_wdata_out,
  output logic [7:0]  mem_byte_en_out,
  output logic [63:0] alu_result_out,
  output logic [63:0] mem_data_out,
  output logic [4:0]  rd_out,
  output logic        rd_write_signal_out,
  output logic        wb_src_signal_out,
  output logic        valid_instr_signal_out,
  output logic        stall_signal_out,
  output logic        misaligned_signal_out,
  output logic        bus_error_signal_out
);

  localparam logic [31:0] TIMEOUT_LAST = (TIMEOUT_CYCLES == 0) ? 32'd0 : 32'(TIMEOUT_CYCLES - 1);

  mem_state_t  state, state_next;

  logic        access;
  logic        squash;
  logic        start;
  logic        ack_take;
  logic        timeout_hit;
  logic        stall;
  logic [31:0] timeout_cnt;

  // Transaction latched at issue; held stable for the whole BUSY phase.
  logic [63:0] lat_addr;
  logic [63:0] lat_wdata;
  logic [7:0]  lat_be;
  logic        lat_we;
  logic [2:0]  lat_width;
  logic [4:0]  lat_rd;
  logic        lat_rd_write;
  logic        lat_wb_src;

  logic [2:0]  align_addr;
  logic [2:0]  align_width;
  logic [7:0]  align_be;
  logic [63:0] align_wdata;
  logic [63:0] align_load;
  logic        align_misaligned;

  assign squash = flush_signal_in | interrupt_signal_in;
  assign access = valid_instr_signal_in & (read_signal_in | write_signal_in) & ~squash;

  // One aligner serves both phases: IDLE needs the incoming address for
  // store lanes and the misalign check, BUSY needs the latched address for
  // load extraction.
  assign align_addr  = (state == BUSY) ? lat_addr[2:0] : alu_result_in[2:0];
  assign align_width = (state == BUSY) ? lat_width     : width_signal_in;

  load_store_align u_align (
    .addr       (align_addr),
    .width      (align_width),
    .rs2        (rs2_value_in),
    .rdata      (mem_rdata_in),
    .byte_en    (align_be),
    .wdata      (align_wdata),
    .load_data  (align_load),
    .misaligned (align_misaligned)
  );

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next  = state;
    stall       = 1'b0;
    start       = 1'b0;
    ack_take    = 1'b0;
    timeout_hit = 1'b0;
    case (state)
      IDLE: begin
        if (access && !align_misaligned) begin
          start      = 1'b1;
          stall      = 1'b1;
          state_next = BUSY;
        end
      end
      BUSY: begin
        if (mem_ack_in) begin
          ack_take   = 1'b1;
          state_next = IDLE;
        end else if ((TIMEOUT_CYCLES != 0) && (timeout_cnt == TIMEOUT_LAST)) begin
          // Abort releases the stall so the dead instruction leaves upstream.
          timeout_hit = 1'b1;
          state_next  = IDLE;
        end else begin
          stall = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Stall is gated by reset so nothing upstream sees a freeze while the
  // stage is being cleared.
  assign stall_signal_out = stall & ~rst_in;
  assign mem_req_out      = (state == BUSY);
  assign mem_we_out       = lat_we;
  assign mem_addr_out     = {lat_addr[63:3], 3'b000};
  assign mem_wdata_out    = lat_wdata;
  assign mem_byte_en_out  = lat_be;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      timeout_cnt <= 32'd0;
    end else if ((state == BUSY) && !mem_ack_in && !timeout_hit && (TIMEOUT_CYCLES != 0)) begin
      timeout_cnt <= timeout_cnt + 32'd1;
    end else begin
      timeout_cnt <= 32'd0;
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      lat_addr               <= 64'd0;
      lat_wdata              <= 64'd0;
      lat_be                 <= 8'd0;
      lat_we                 <= 1'b0;
      lat_width              <= 3'd0;
      lat_rd                 <= 5'd0;
      lat_rd_write           <= 1'b0;
      lat_wb_src             <= 1'b0;
      alu_result_out         <= 64'd0;
      mem_data_out           <= 64'd0;
      rd_out                 <= 5'd0;
      rd_write_signal_out    <= 1'b0;
      wb_src_signal_out      <= 1'b0;
      valid_instr_signal_out <= 1'b0;
      misaligned_signal_out  <= 1'b0;
      bus_error_signal_out   <= 1'b0;
    end else begin
      misaligned_signal_out <= 1'b0;
      bus_error_signal_out  <= 1'b0;
      if (state == IDLE) begin
        if (start) begin
          // WB registers keep their value while the access is in flight.
          lat_addr     <= alu_result_in;
          lat_wdata    <= align_wdata;
          lat_be       <= align_be;
          lat_we       <= write_signal_in;
          lat_width    <= width_signal_in;
          lat_rd       <= rd_in;
          lat_rd_write <= rd_write_signal_in;
          lat_wb_src   <= wb_src_signal_in;
        end else begin
          alu_result_out <= alu_result_in;
          rd_out         <= rd_in;
          mem_data_out   <= 64'd0;
          if (access || squash) begin
            // Here access implies misaligned; squashed or faulting
            // instructions reach writeback as bubbles.
            misaligned_signal_out  <= access;
            rd_write_signal_out    <= 1'b0;
            wb_src_signal_out      <= 1'b0;
            valid_instr_signal_out <= 1'b0;
          end else begin
            rd_write_signal_out    <= rd_write_signal_in;
            wb_src_signal_out      <= wb_src_signal_in;
            valid_instr_signal_out <= valid_instr_signal_in;
          end
        end
      end else if (ack_take) begin
        alu_result_out         <= lat_addr;
        mem_data_out           <= lat_we ? 64'd0 : align_load;
        rd_out                 <= lat_rd;
        rd_write_signal_out    <= lat_rd_write;
        wb_src_signal_out      <= lat_wb_src;
        valid_instr_signal_out <= 1'b1;
      end else if (timeout_hit) begin
        bus_error_signal_out   <= 1'b1;
        rd_write_signal_out    <= 1'b0;
        valid_instr_signal_out <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_memory_access.sv
// tb/tb_memory_access.sv - self-checking bench for memory_access with a behavioural reference model
module tb_memory_access;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [63:0] alu_result_in = '0;
  logic [63:0] rs2_value_in = '0;
  logic [4:0]  rd_in = '0;
  logic [2:0]  width_signal_in = '0;
  logic        rd_write_signal_in = 1'b0;
  logic        read_signal_in = 1'b0;
  logic        write_signal_in = 1'b0;
  logic        wb_src_signal_in = 1'b0;
  logic        valid_instr_signal_in = 1'b0;
  logic        flush_signal_in = 1'b0;
  logic        interrupt_signal_in = 1'b0;
  logic        mem_ack_in = 1'b0;
  logic [63:0] mem_rdata_in = '0;

  logic        mem_req_out;
  logic        mem_we_out;
  logic [63:0] mem_addr_out;
  logic [63:0] mem_wdata_out;
  logic [7:0]  mem_byte_en_out;
  logic [63:0] alu_result_out;
  logic [63:0] mem_data_out;
  logic [4:0]  rd_out;
  logic        rd_write_signal_out;
  logic        wb_src_signal_out;
  logic        valid_instr_signal_out;
  logic        stall_signal_out;
  logic        misaligned_signal_out;
  logic        bus_error_signal_out;

  memory_access #(.TIMEOUT_CYCLES(TO)) dut (
    .clk_in                 (clk),
    .rst_in                 (rst),
    .alu_result_in          (alu_result_in),
    .rs2_value_in           (rs2_value_in),
    .rd_in                  (rd_in),
    .width_signal_in        (width_signal_in),
    .rd_write_signal_in     (rd_write_signal_in),
    .read_signal_in         (read_signal_in),
    .write_signal_in        (write_signal_in),
    .wb_src_signal_in       (wb_src_signal_in),
    .valid_instr_signal_in  (valid_instr_signal_in),
    .flush_signal_in        (flush_signal_in),
    .interrupt_signal_in    (interrupt_signal_in),
    .mem_ack_in             (mem_ack_in),
    .mem_rdata_in           (mem_rdata_in),
    .mem_req_out            (mem_req_out),
    .mem_we_out             (mem_we_out),
    .mem_addr_out           (mem_addr_out),
    .mem_wdata_out          (mem_wdata_out),
    .mem_byte_en_out        (mem_byte_en_out),
    .alu_result_out         (alu_result_out),
    .mem_data_out           (mem_data_out),
    .rd_out                 (rd_out),
    .rd_write_signal_out    (rd_write_signal_out),
    .wb_src_signal_out      (wb_src_signal_out),
    .valid_instr_signal_out (valid_instr_signal_out),
    .stall_signal_out       (stall_signal_out),
    .misaligned_signal_out  (misaligned_signal_out),
    .bus_error_signal_out   (bus_error_signal_out)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int nbytes(input logic [2:0] w);
    return 1 << w[1:0];
  endfunction

  function automatic bit is_mis(input logic [63:0] a, input logic [2:0] w);
    return (int'(a[2:0]) % nbytes(w)) != 0;
  endfunction

  function automatic logic [7:0] m_be(input logic [63:0] a, input logic [2:0] w);
    logic [7:0] be;
    int off = int'(a[2:0]);
    int n = nbytes(w);
    for (int i = 0; i < 8; i++) be[i] = (i >= off) && (i < off + n);
    return be;
  endfunction

  function automatic logic [63:0] m_wdata(input logic [63:0] a, input logic [63:0] d);
    logic [63:0] r = '0;
    int off = int'(a[2:0]);
    for (int i = 0; i < 8; i++) if (i >= off) r[8*i +: 8] = d[8*(i-off) +: 8];
    return r;
  endfunction

  function automatic logic [63:0] m_load(input logic [63:0] a, input logic [2:0] w, input logic [63:0] rd);
    logic [63:0] v = '0;
    int off = int'(a[2:0]);
    int n = nbytes(w);
    for (int i = 0; i < n; i++) v[8*i +: 8] = rd[8*(off+i) +: 8];
    if (!w[2] && n < 8 && v[8*n-1]) for (int j = 8*n; j < 64; j++) v[j] = 1'b1;
    return v;
  endfunction

  bit          m_busy = 0;
  int          m_cnt = 0;
  logic [63:0] l_addr = '0, l_rs2 = '0;
  logic [2:0]  l_w = '0;
  logic [4:0]  l_rd = '0;
  bit          l_we = 0, l_rdw = 0, l_wbs = 0;
  logic [63:0] e_alu = '0, e_mdata = '0;
  logic [4:0]  e_rd = '0;
  bit          e_rdw = 0, e_wbs = 0, e_valid = 0, e_mis = 0, e_berr = 0, e_data_chk = 1;

  always @(negedge clk) begin
    bit acc, mis, to;
    if (rst) begin
      chk("rst_req", mem_req_out, 0);
      chk("rst_stall", stall_signal_out, 0);
      chk("rst_valid", valid_instr_signal_out, 0);
      chk("rst_rd_write", rd_write_signal_out, 0);
      chk("rst_alu_result", alu_result_out, 0);
      chk("rst_mem_data", mem_data_out, 0);
      chk("rst_misaligned", misaligned_signal_out, 0);
      chk("rst_bus_error", bus_error_signal_out, 0);
      m_busy = 0; m_cnt = 0;
      e_alu = '0; e_mdata = '0; e_rd = '0;
      e_rdw = 0; e_wbs = 0; e_valid = 0; e_mis = 0; e_berr = 0; e_data_chk = 1;
    end else begin
      chk("valid_out", valid_instr_signal_out, e_valid);
      chk("rd_write_out", rd_write_signal_out, e_rdw);
      chk("misaligned", misaligned_signal_out, e_mis);
      chk("bus_error", bus_error_signal_out, e_berr);
      if (e_valid) begin
        chk("alu_result_out", alu_result_out, e_alu);
        chk("rd_out", rd_out, e_rd);
        chk("wb_src_out", wb_src_signal_out, e_wbs);
      end
      if (e_data_chk) chk("mem_data_out", mem_data_out, e_mdata);

      acc = valid_instr_signal_in && (read_signal_in || write_signal_in)
            && !flush_signal_in && !interrupt_signal_in;
      mis = is_mis(alu_result_in, width_signal_in);
      e_mis = 0;
      e_berr = 0;
      if (!m_busy) begin
        chk("idle_req", mem_req_out, 0);
        chk("idle_stall", stall_signal_out, acc && !mis);
        e_mis = acc && mis;
        if (acc && !mis) begin
          l_addr = alu_result_in; l_rs2 = rs2_value_in; l_w = width_signal_in;
          l_rd = rd_in; l_we = write_signal_in; l_rdw = rd_write_signal_in; l_wbs = wb_src_signal_in;
          m_busy = 1; m_cnt = 0;
        end else begin
          e_alu = alu_result_in; e_rd = rd_in; e_data_chk = 0;
          if (acc || flush_signal_in || interrupt_signal_in) begin
            e_rdw = 0; e_wbs = 0; e_valid = 0;
          end else begin
            e_rdw = rd_write_signal_in; e_wbs = wb_src_signal_in; e_valid = valid_instr_signal_in;
          end
        end
      end else begin
        to = (TO != 0) && !mem_ack_in && (m_cnt + 1 == TO);
        chk("busy_req", mem_req_out, 1);
        chk("busy_stall", stall_signal_out, !mem_ack_in && !to);
        chk("busy_addr", mem_addr_out, {l_addr[63:3], 3'b000});
        chk("busy_we", mem_we_out, l_we);
        chk("busy_byte_en", mem_byte_en_out, m_be(l_addr, l_w));
        if (l_we) chk("busy_wdata", mem_wdata_out, m_wdata(l_addr, l_rs2));
        if (mem_ack_in) begin
          e_alu = l_addr; e_rd = l_rd; e_rdw = l_rdw; e_wbs = l_wbs; e_valid = 1;
          e_mdata = l_we ? 64'd0 : m_load(l_addr, l_w, mem_rdata_in);
          e_data_chk = 1;
          m_busy = 0;
        end else if (to) begin
          m_busy = 0; e_berr = 1; e_valid = 0; e_rdw = 0;
        end else begin
          m_cnt++;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    alu_result_in = '0; rs2_value_in = '0; rd_in = '0; width_signal_in = '0;
    rd_write_signal_in = 0; read_signal_in = 0; write_signal_in = 0; wb_src_signal_in = 0;
    valid_instr_signal_in = 0; flush_signal_in = 0; interrupt_signal_in = 0;
  endtask

  task automatic set_ld(input logic [63:0] a, input logic [2:0] w, input logic [4:0] r);
    idle_in();
    alu_result_in = a; width_signal_in = w; rd_in = r;
    read_signal_in = 1; rd_write_signal_in = 1; wb_src_signal_in = 1; valid_instr_signal_in = 1;
  endtask

  task automatic set_st(input logic [63:0] a, input logic [2:0] w, input logic [63:0] d);
    idle_in();
    alu_result_in = a; width_signal_in = w; rs2_value_in = d;
    write_signal_in = 1; valid_instr_signal_in = 1;
  endtask

  // Runs from the IDLE cycle up to the ack cycle (sampling point), counting stall/req cycles.
  task automatic run_mem(input int wait_cycles, input logic [63:0] rdata, output int stall_cnt, output int req_cnt);
    stall_cnt = 0; req_cnt = 0;
    #1; stall_cnt += int'(stall_signal_out); req_cnt += int'(mem_req_out);
    step();
    for (int i = 0; i < wait_cycles; i++) begin
      #1; stall_cnt += int'(stall_signal_out); req_cnt += int'(mem_req_out);
      step();
    end
    mem_ack_in = 1; mem_rdata_in = rdata;
    #1; stall_cnt += int'(stall_signal_out); req_cnt += int'(mem_req_out);
  endtask

  task automatic end_ack();
    step();
    mem_ack_in = 0; mem_rdata_in = '0;
    idle_in();
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int sc, rc;
    bit rel;

    repeat (2) @(posedge clk);
    #1;
    chk("reset_req", mem_req_out, 0);
    chk("reset_valid", valid_instr_signal_out, 0);
    rst = 0;

    // ack while idle is ignored
    step();
    mem_ack_in = 1;
    step();
    mem_ack_in = 0;
    #1 chk("idle_ack_req", mem_req_out, 0);

    // ALU pass-through
    step();
    idle_in();
    alu_result_in = 64'h1234_5678_9ABC_DEF0; rd_in = 5; rd_write_signal_in = 1; valid_instr_signal_in = 1;
    #1 chk("alu_stall", stall_signal_out, 0);
    step();
    idle_in();
    #1 chk("alu_pass", alu_result_out, 64'h1234_5678_9ABC_DEF0);
    chk("alu_rd", rd_out, 5);

    // LB at 0x1003, byte3 = 0x80
    step();
    set_ld(64'h1003, 3'b000, 7);
    run_mem(0, 64'h0000_0000_8000_0000, sc, rc);
    chk("lb_addr", mem_addr_out, 64'h1000);
    chk("lb_byte_en", mem_byte_en_out, 8'h08);
    chk("lb_ack_stall", stall_signal_out, 0);
    end_ack();
    chk("lb_data", mem_data_out, 64'hFFFF_FFFF_FFFF_FF80);
    chk("lb_stall_cycles", sc, 1);

    // LBU at 0x1003
    set_ld(64'h1003, 3'b100, 7);
    run_mem(0, 64'h0000_0000_8000_0000, sc, rc);
    end_ack();
    chk("lbu_data", mem_data_out, 64'h0000_0000_0000_0080);

    // SH at 0x2006
    set_st(64'h2006, 3'b001, 64'h1234);
    run_mem(0, 64'd0, sc, rc);
    chk("sh_we", mem_we_out, 1);
    chk("sh_byte_en", mem_byte_en_out, 8'hC0);
    chk("sh_wdata_hi", {48'd0, mem_wdata_out[63:48]}, 64'h1234);
    end_ack();
    chk("sh_rd_write", rd_write_signal_out, 0);
    chk("sh_valid", valid_instr_signal_out, 1);

    // LD with ack after 3 BUSY cycles
    set_ld(64'h3000, 3'b011, 12);
    run_mem(3, 64'h0123_4567_89AB_CDEF, sc, rc);
    chk("ld_ack_stall", stall_signal_out, 0);
    end_ack();
    chk("ld_stall_cycles", sc, 4);
    chk("ld_req_cycles", rc, 4);
    chk("ld_data", mem_data_out, 64'h0123_4567_89AB_CDEF);

    // Misaligned LW at 0x1002
    set_ld(64'h1002, 3'b010, 9);
    #1 chk("lw_mis_req", mem_req_out, 0);
    chk("lw_mis_stall", stall_signal_out, 0);
    step();
    idle_in();
    #1 chk("lw_mis_pulse", misaligned_signal_out, 1);
    chk("lw_mis_valid", valid_instr_signal_out, 0);
    chk("lw_mis_rd_write", rd_write_signal_out, 0);
    step();
    #1 chk("lw_mis_pulse_end", misaligned_signal_out, 0);

    // Timeout: ack never arrives
    set_ld(64'h4000, 3'b011, 3);
    #1 chk("to_idle_stall", stall_signal_out, 1);
    step();
    rc = 0; rel = 0;
    for (int i = 0; i < 10 && !rel; i++) begin
      #1;
      if (mem_req_out) rc++;
      if (!stall_signal_out) rel = 1;
      step();
    end
    idle_in();
    chk("to_released", rel, 1);
    chk("to_req_cycles", rc, TO);
    #1 chk("to_bus_error", bus_error_signal_out, 1);
    chk("to_req_low", mem_req_out, 0);
    chk("to_valid", valid_instr_signal_out, 0);
    step();
    #1 chk("to_bus_error_end", bus_error_signal_out, 0);

    // Flushed store and interrupted load never issue
    set_st(64'h5000, 3'b011, 64'hAAAA_BBBB_CCCC_DDDD);
    flush_signal_in = 1;
    #1 chk("flush_req", mem_req_out, 0);
    chk("flush_stall", stall_signal_out, 0);
    step();
    set_ld(64'h7000, 3'b011, 4);
    interrupt_signal_in = 1;
    #1 chk("flush_req_after", mem_req_out, 0);
    chk("flush_valid", valid_instr_signal_out, 0);
    chk("intr_stall", stall_signal_out, 0);
    step();
    idle_in();
    #1 chk("intr_req", mem_req_out, 0);

    // Pass-through so alu_result_out is nonzero before the reset test
    alu_result_in = 64'h55; valid_instr_signal_in = 1;
    step();
    idle_in();

    // Reset during BUSY
    set_st(64'h6008, 3'b011, 64'hDEAD_BEEF_0000_1111);
    step();
    #1 chk("rstb_req_before", mem_req_out, 1);
    #1 rst = 1;
    #1 chk("rstb_req", mem_req_out, 0);
    chk("rstb_stall", stall_signal_out, 0);
    chk("rstb_we", mem_we_out, 0);
    chk("rstb_byte_en", mem_byte_en_out, 0);
    chk("rstb_addr", mem_addr_out, 0);
    chk("rstb_alu_result", alu_result_out, 0);
    chk("rstb_valid", valid_instr_signal_out, 0);
    step();
    idle_in();
    step();
    rst = 0;

    // Normal operation after reset
    step();
    set_ld(64'h8004, 3'b010, 2);
    run_mem(1, 64'hF000_0000_0000_0000, sc, rc);
    end_ack();
    chk("post_rst_lw", mem_data_out, 64'hFFFF_FFFF_F000_0000);
    step();
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
